// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group is
// resolved per stage, and the inter-group carry is registered between stages.
`timescale 1ns/1ps
module cla_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int GROUP = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int NSTAGE = WIDTH / GROUP;
    localparam int NCELL  = GROUP / 4;

    // Handshake: a bundle moves in when in_valid && in_ready, and a result
    // moves out when out_valid && out_ready. The whole pipe advances together
    // whenever the output slot is empty or being drained, so in_ready never
    // depends on in_valid.
    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = in_sub ? ~in_b : in_b;
    assign c0       = in_sub ^ in_cin;

    // GROUP-bit lookahead built from 4-bit cells; returns {carry_out, sum}.
    function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] a,
                                                 input logic [GROUP-1:0] b,
                                                 input logic             cin);
        logic [GROUP-1:0] p, g, c;
        logic [NCELL-1:0] cg, cp;
        logic [NCELL:0]   cc;
        logic             acc, run;
        p = a ^ b;
        g = a & b;
        for (int j = 0; j < NCELL; j++) begin
            cg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            cp[j] = &p[4*j +: 4];
        end
        cc[0] = cin;
        for (int j = 0; j < NCELL; j++) begin
            acc = cg[j];
            run = cp[j];
            for (int i = j - 1; i >= 0; i--) begin
                acc = acc | (run & cg[i]);
                run = run & cp[i];
            end
            cc[j+1] = acc | (run & cin);
        end
        for (int j = 0; j < NCELL; j++) begin
            c[4*j]   = cc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & cc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & cc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & cc[j]);
        end
        return {cc[NCELL], p ^ c};
    endfunction

    genvar k;
    for (k = 0; k < NSTAGE; k++) begin : stg
        localparam int RIN  = WIDTH - k*GROUP;  // operand bits still unresolved on entry
        localparam int SOUT = (k+1)*GROUP;      // sum bits resolved after this stage

        logic [RIN-1:0]  a_in, b_in;
        logic            c_in, v_in;
        logic [GROUP:0]  res;
        logic [SOUT-1:0] sum_d;
        logic            vld_q, c_q;
        logic [SOUT-1:0] sum_q;

        if (k == 0) begin : g_first
            assign a_in  = in_a;
            assign b_in  = b_eff;
            assign c_in  = c0;
            assign v_in  = in_valid;
            assign sum_d = res[GROUP-1:0];
        end else begin : g_next
            assign a_in  = stg[k-1].g_rem.a_q;
            assign b_in  = stg[k-1].g_rem.b_q;
            assign c_in  = stg[k-1].c_q;
            assign v_in  = stg[k-1].vld_q;
            assign sum_d = {res[GROUP-1:0], stg[k-1].sum_q};
        end

        assign res = cla_group(a_in[GROUP-1:0], b_in[GROUP-1:0], c_in);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else begin
                if (flush)    vld_q <= 1'b0;
                else if (adv) vld_q <= v_in;
                if (adv) begin
                    c_q   <= res[GROUP];
                    sum_q <= sum_d;
                end
            end
        end

        if (k < NSTAGE - 1) begin : g_rem
            logic [RIN-GROUP-1:0] a_q, b_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[RIN-1:GROUP];
                    b_q <= b_in[RIN-1:GROUP];
                end
            end
        end else begin : g_last
            // The sign bits live in the top group, so flags are formed here.
            logic ovf_q, zero_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= (a_in[RIN-1] == b_in[RIN-1]) && (res[GROUP-1] != a_in[RIN-1]);
                    zero_q <= (sum_d == '0);
                end
            end
        end
    end

    assign out_valid = stg[NSTAGE-1].vld_q;
    assign out_sum   = stg[NSTAGE-1].sum_q;
    assign out_cout  = stg[NSTAGE-1].c_q;
    assign out_ovf   = stg[NSTAGE-1].g_last.ovf_q;
    assign out_zero  = stg[NSTAGE-1].g_last.zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: directed vector table, multi-cycle handshake
// sequences, and a randomized stream checked against an arithmetic model.
`timescale 1ns/1ps
module tb_cla_pipe_addsub;
    localparam int W   = 32;
    localparam int G   = 16;
    localparam int NST = W / G;
    localparam int NRAND = 10000;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, in_sub, in_cin;
    logic         out_valid, out_ready, out_cout, out_ovf, out_zero;
    logic [W-1:0] in_a, in_b, out_sum;

    int total = 0;
    int bad   = 0;
    int n_pop = 0;
    int n_push = 0;
    logic [W+2:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;
    vec_t vecs[9];

    cla_pipe_addsub #(.WIDTH(W), .GROUP(G)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // reference model: signed and unsigned results with plain integer arithmetic
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub, input logic cin);
        longint sa, sb, ua, ub, r, ur;
        logic [W-1:0] s;
        logic co, ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        if (sub) begin
            r  = sa - sb - longint'(cin);
            ur = ua - ub - longint'(cin);
            co = (ur >= 0);
        end else begin
            r  = sa + sb + longint'(cin);
            ur = ua + ub + longint'(cin);
            co = (ur >= (longint'(1) <<< W));
        end
        s  = ur[W-1:0];
        ov = (r > ((longint'(1) <<< (W-1)) - 1)) || (r < -(longint'(1) <<< (W-1)));
        return {(s == '0), ov, co, s};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: results checked on consumption, bundles queued on acceptance
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_extra: got result %0h with no bundle outstanding", out_sum);
                end else begin
                    check("sb_result", {out_zero, out_ovf, out_cout, out_sum}, exp_q.pop_front());
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_sub, in_cin));
                n_push++;
            end
        end
    end

    always @(posedge rst) exp_q.delete();

    // driver tasks (called at posedge + 1)
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin);
        in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
        for (int n = 0; n <= 200; n++) begin
            @(negedge clk);
            if (in_ready) break;
            if (n == 200) check("send_accept", in_ready, 1'b1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_out", out_valid, 1'b1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        bit ok;
        send(v.a, v.b, v.sub, v.cin);
        wait_out(ok);
        if (ok) check(name, {out_zero, out_ovf, out_cout, out_sum}, {v.zero, v.ovf, v.cout, v.sum});
        step();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h0000_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        bit ok;
        bit done;
        int cyc, p0;
        logic [W+3:0] snap;

        vecs[0] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1, 32'h1234_5677, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_sum",   out_sum, '0);
        check("rst_cout",  out_cout, 1'b0);
        check("rst_ovf",   out_ovf, 1'b0);
        check("rst_zero",  out_zero, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        step();

        // latency and inter-stage carry
        send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        cyc = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            cyc++;
            if (out_valid) break;
        end
        check("latency", cyc, NST);
        check("lat_result", {out_zero, out_ovf, out_cout, out_sum}, {3'b000, 32'h0001_0000});
        step();

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // backpressure mid-stream
        p0 = n_pop;
        fork
            begin
                for (int i = 0; i < 5; i++) send(32'h1000_0000 * i + 32'h0000_FFF0, 32'h0000_0020 + i, 1'(i % 2), 1'b0);
            end
            begin
                wait_out(ok);
                @(posedge clk);
                #1 out_ready = 1'b0;
                snap = {out_valid, out_zero, out_ovf, out_cout, out_sum};
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 1'b0);
                    check("bp_hold", {out_valid, out_zero, out_ovf, out_cout, out_sum}, snap);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        for (int n = 0; n < 20; n++) begin
            step();
            if (exp_q.size() == 0) break;
        end
        check("bp_drain", exp_q.size(), 0);
        check("bp_count", n_pop - p0, 5);

        // flush with two bundles in flight and a third presented
        out_ready = 1'b0;
        send(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0);
        send(32'h0000_0033, 32'h0000_0044, 1'b0, 1'b0);
        in_a = 32'h0000_0055; in_b = 32'h0000_0066; in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("flush_quiet", out_valid, 1'b0);
        end
        step();
        run_vec(vecs[4], "flush_resume");

        // reset while bundles are in flight
        send(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0);
        send(32'h0000_0300, 32'h0000_0400, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_sum",   out_sum, '0);
        check("arst_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("arst_quiet", out_valid, 1'b0);
        end
        step();

        // random regression with random backpressure and bubbles
        p0 = n_pop;
        cyc = n_push;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < NRAND; i++) begin
                    send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) step();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            step();
            if (exp_q.size() == 0) break;
        end
        check("rand_drain", exp_q.size(), 0);
        check("rand_accepted", n_push - cyc, NRAND);
        check("rand_count", n_pop - p0, NRAND);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor for the datapath ALU. It is the next generation of the 16-bit grouped CLA adder. The operand width is split into GROUP-bit lookahead groups, one group is resolved per pipeline stage, and the inter-group carry is registered between stages. The block adds a subtract mode, carry/borrow chaining, signed-overflow and zero flags, a valid/ready handshake with backpressure, and a synchronous flush.

## Interface
- WIDTH, 32: operand width. Must be a multiple of GROUP.
- GROUP, 16: bits resolved per stage. Must be a multiple of 4, built from 4-bit lookahead cells with group G/P.
- NSTAGE, WIDTH/GROUP: derived, not overridable. Pipeline depth.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; invalidates every stage.
- in_valid  in  1  operand bundle present.
- in_ready  out  1  block accepts the bundle this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0 computes A+B+cin; 1 computes A−B−cin (borrow-in).
- in_cin  in  1  carry-in (add mode) or borrow-in (sub mode).
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- out_sum  out  WIDTH  result modulo 2^WIDTH.
- out_cout  out  1  carry out of the MSB. In sub mode, 1 means no borrow.
- out_ovf  out  1  signed two's-complement overflow.
- out_zero  out  1  out_sum == 0.

## Operation
- Input conditioning:
  - Effective B is b' = in_sub ? ~in_b : in_b.
  - Effective carry-in is c0 = in_sub ? ~in_cin : in_cin.
- Stage k (0..NSTAGE−1) resolves bits [k·GROUP +: GROUP] with 4-bit CLA cells and a group-level lookahead carry. Its carry-in is the registered carry from stage k−1 (c0 for stage 0).
- Operand bits for later groups travel in skew registers. Already-resolved sum bits travel forward with the bundle. Each stage register holds valid, partial sum, carry, remaining a/b' bits, and the sign bits needed for overflow.
- Flag rules:
  - out_ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]).
  - out_cout = carry out of bit WIDTH−1.
  - out_zero is computed on the final registered sum.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv.
  - When adv=1, every stage register loads from its predecessor, and stage 0 loads {in_valid, ...}.
  - When adv=0, all stages hold. No bubble collapsing.
- A bundle is accepted on a cycle where in_valid && in_ready. A result is consumed on a cycle where out_valid && out_ready.
- flush=1 clears every stage valid bit at the next edge, including a bundle presented on the same cycle. flush has priority over adv. Data registers may keep stale values.
- Reset: all valid bits are 0 and all data/flag registers are 0. So out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0, and in_ready=1 immediately after reset.
- Reset asserted mid-operation discards all in-flight bundles. No partial result is ever presented.

## Timing
- Latency: a bundle accepted at edge t appears on out_* after edge t+NSTAGE−1, i.e. visible in cycle t+NSTAGE with no stall. For WIDTH=32, GROUP=16 the latency is 2 cycles.
- Throughput: one result per cycle while out_ready=1.
- out_* are registered outputs and hold stable while out_valid && !out_ready.
- in_ready is combinational from out_valid and out_ready only, with no path from in_valid. out_ready→in_ready is the only comb path through the block.
- Critical path per stage: one GROUP-bit lookahead plus sum XOR. It is independent of WIDTH.
- Corner cases:
  - WIDTH==GROUP gives NSTAGE=1, a single registered stage with latency 1.
  - in_valid=0 while adv=1 inserts a bubble: the next valid=0 propagates.

## Test plan
- Reset then add, WIDTH=32/GROUP=16. Hold rst, then release; require all outputs 0 and in_ready=1. Send 0x0000FFFF + 0x00000001, cin=0. Require out_sum=0x00010000, cout=0, ovf=0, zero=0, and out_valid exactly 2 cycles after acceptance. This checks the inter-stage carry.
- Subtract with borrow and flags:
  - 0x00000005 − 0x00000005, cin=0 → sum=0, zero=1, cout=1.
  - 0x00000000 − 0x00000001 → sum=0xFFFFFFFF, cout=0.
  - 0x80000000 − 1 → sum=0x7FFFFFFF, ovf=1.
- Add overflow and wrap:
  - 0x7FFFFFFF + 1 → sum=0x80000000, ovf=1, cout=0.
  - 0xFFFFFFFF + 0xFFFFFFFF, cin=1 → sum=0xFFFFFFFF, cout=1, ovf=0.
- Backpressure: stream 5 back-to-back bundles and drop out_ready for 3 cycles mid-stream. Require in_ready=0 during the stall, out_* stable, and all 5 results delivered in order with no loss or duplication.
- Flush and mid-flight reset:
  - Accept 2 bundles, then pulse flush with in_valid=1. Require no out_valid for those 3 bundles, then normal operation resumes.
  - Separately, assert rst while bundles are in flight. Require out_valid=0 asynchronously.
- Random regression for WIDTH∈{16,32,64} and GROUP∈{4,16}: 10k random a/b/sub/cin against a reference model, with random out_ready. Compare sum, cout, ovf, and zero.
